// File: rtl/soc_io_pkg.sv
// Shared definitions for the memory-mapped I/O page: register offsets, status
// bit positions and the UART transmitter state type.
package soc_io_pkg;

    // Register offsets as seen on mem_addr[3:2]
    localparam logic [1:0] LED_OFS         = 2'd0;
    localparam logic [1:0] UART_DATA_OFS   = 2'd1;
    localparam logic [1:0] UART_STATUS_OFS = 2'd2;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_BUSY_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy
// count; a push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/soc_io.sv
// Memory-mapped I/O page: LED register, buffered 8N1 UART transmitter and a
// status register, with registered single-cycle read data.
module soc_io
    import soc_io_pkg::*;
#(
    parameter int unsigned LED_WIDTH      = 6,
    parameter bit          LED_ACTIVE_LOW = 1'b1,
    parameter int unsigned CLK_FREQ_HZ    = 12000000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned IO_SEL_BIT     = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wmask,
    input  logic                 mem_rstrb,
    output logic [31:0]          mem_rdata,
    output logic                 io_sel,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 TXD
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

    // Bus decode
    logic [1:0] reg_ofs;
    logic       wr_en, rd_en, led_we, fifo_push, status_rd;
    logic       unused_bits;

    assign io_sel      = mem_addr[IO_SEL_BIT];
    assign reg_ofs     = mem_addr[3:2];
    assign wr_en       = io_sel && (mem_wmask != 4'b0);
    assign rd_en       = io_sel && mem_rstrb;
    assign led_we      = wr_en && (reg_ofs == LED_OFS);
    assign fifo_push   = wr_en && (reg_ofs == UART_DATA_OFS);
    assign status_rd   = rd_en && (reg_ofs == UART_STATUS_OFS);
    assign unused_bits = ^{mem_addr, mem_wdata};

    // TX FIFO
    logic [7:0]       fifo_rdata;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (mem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // UART shifter
    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             div_last, tx_busy;

    assign div_last = (div_q == DIV_W'(CLKS_PER_BIT - 1));
    assign tx_busy  = !fifo_empty || (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    div_d    = '0;
                    bit_d    = '0;
                    txd_d    = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (div_last) begin
                    div_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = StData;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StData: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StStop: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registers and read path
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          rdata_q, rdata_d, status_word;
    logic                 ovf_q, ovf_d, ovf_set;

    // A dropped push outranks the read-to-clear in the same cycle
    assign ovf_set = fifo_push && fifo_full && !fifo_pop;
    assign ovf_d   = ovf_set ? 1'b1 : (status_rd ? 1'b0 : ovf_q);

    always_comb begin
        status_word                            = '0;
        status_word[STAT_FULL_BIT]             = fifo_full;
        status_word[STAT_BUSY_BIT]             = tx_busy;
        status_word[STAT_OVF_BIT]              = ovf_q;
        status_word[STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (reg_ofs)
                LED_OFS:         rdata_d = 32'(led_q);
                UART_STATUS_OFS: rdata_d = status_word;
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q   <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            if (led_we) led_q <= mem_wdata[LED_WIDTH-1:0];
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign TXD       = txd_q;
    assign LEDS      = LED_ACTIVE_LOW ? ~led_q : led_q;

endmodule

// File: tb/tb_soc_io.sv
// Self-checking bench for soc_io: directed boundary cases plus randomized
// register traffic and byte bursts, with a serial-line decoder as reference.
module tb_soc_io;

    localparam int unsigned CPB   = 10;
    localparam int unsigned FRAME = 10 * CPB + 1;
    localparam logic [31:0] LED_A  = 32'h0040_0000;
    localparam logic [31:0] DATA_A = 32'h0040_0004;
    localparam logic [31:0] STAT_A = 32'h0040_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata_al;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb, io_sel, io_sel_al, TXD, txd_al;
    logic [5:0]  LEDS, leds_al;

    always #5 clk = ~clk;

    soc_io #(
        .LED_WIDTH(6), .LED_ACTIVE_LOW(1'b0), .CLK_FREQ_HZ(1000000),
        .BAUD(100000), .TX_DEPTH(4), .IO_SEL_BIT(22)
    ) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .io_sel(io_sel), .LEDS(LEDS), .TXD(TXD)
    );

    soc_io #(
        .LED_WIDTH(6), .LED_ACTIVE_LOW(1'b1), .CLK_FREQ_HZ(1000000),
        .BAUD(100000), .TX_DEPTH(4), .IO_SEL_BIT(22)
    ) u_dut_al (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(rdata_al),
        .io_sel(io_sel_al), .LEDS(leds_al), .TXD(txd_al)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        tick();
        mem_wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
    endtask

    function automatic logic [31:0] status(input bit full, input bit busy, input bit ovf,
                                           input int count);
        return {16'h0, 8'(count), 5'h0, ovf, busy, full};
    endfunction

    // Reference model state
    logic [5:0]  led_m;
    logic [31:0] rd_m;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b0;

    // Serial decoder: samples each bit in the middle of its CPB-clock slot
    initial begin : monitor
        int         t;
        logic [7:0] by;
        t  = -1;
        by = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 || !mon_en) t = -1;
            else if (t < 0) begin
                if (TXD === 1'b0) t = 0;
            end else t++;
            if (t >= 0 && (t % CPB) == CPB / 2) begin
                if (t < int'(CPB)) check("mon_start", {31'h0, TXD}, 32'h0);
                else if (t < int'(9 * CPB)) by[t / CPB - 1] = TXD;
                else begin
                    check("mon_stop", {31'h0, TXD}, 32'h1);
                    if (exp_q.size() == 0) check("mon_unexpected", {24'h0, by}, 32'hFFFF_FFFF);
                    else check("mon_byte", {24'h0, by}, {24'h0, exp_q.pop_front()});
                    t = -1;
                end
            end
        end
    end

    logic [31:0] a, d;
    logic [3:0]  m;
    logic [7:0]  b [7];
    logic [7:0]  byt;
    logic [9:0]  fb;
    int          n, t_push, p0, lows, ofs;

    initial begin
        reset = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("reset_txd", {31'h0, TXD}, 32'h1);
        check("reset_txd_al", {31'h0, txd_al}, 32'h1);
        check("reset_leds", {26'h0, LEDS}, 32'h0);
        check("reset_leds_al", {26'h0, leds_al}, 32'h3F);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_rdata_al", rdata_al, 32'h0);
        bus_read(STAT_A);
        check("reset_status", mem_rdata, 32'h0);
        rd_m = 32'h0; led_m = 6'h0; mon_en = 1'b1;

        // LED register
        bus_write(LED_A, 32'h3F, 4'hF);
        led_m = 6'h3F;
        check("led_write", {26'h0, LEDS}, 32'h3F);
        check("led_write_al", {26'h0, leds_al}, 32'h0);
        bus_read(LED_A);
        check("led_readback", mem_rdata, 32'h3F);
        rd_m = 32'h3F;

        // Single frame, cycle exact
        exp_q.push_back(8'h55);
        bus_write(DATA_A, 32'h55, 4'h1);
        n = 0;
        while (TXD !== 1'b0 && n < 20) begin tick(); n++; end
        check("pop_latency", n, 1);
        fb = {1'b1, 8'h55, 1'b0};
        mem_addr = STAT_A;
        for (int t = 0; t < int'(10 * CPB); t++) begin
            check("frame_txd", {31'h0, TXD}, {31'h0, fb[t / CPB]});
            if (t == 50) mem_rstrb = 1'b1;
            tick();
            if (t == 50) begin
                mem_rstrb = 1'b0;
                check("busy_mid_frame", mem_rdata, status(0, 1, 0, 0));
            end
        end
        check("frame_idle", {31'h0, TXD}, 32'h1);
        repeat (5) tick();
        bus_read(STAT_A);
        check("idle_status", mem_rdata, 32'h0);

        // Overflow: one byte pops at once, four queue, the sixth is dropped
        for (int i = 0; i < 7; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            d = $urandom; d[7:0] = b[i];
            bus_write(DATA_A, d, 4'($urandom_range(1, 15)));
            if (i == 0) t_push = cyc;
            if (i < 5) exp_q.push_back(b[i]);
        end
        bus_read(STAT_A);
        check("ovf_status", mem_rdata, status(1, 1, 1, 4));
        bus_read(STAT_A);
        check("ovf_cleared", mem_rdata, status(1, 1, 0, 4));

        // Push on the exact edge the shifter pops the next byte while full
        while (cyc < t_push + int'(FRAME)) tick();
        d = $urandom; d[7:0] = b[6];
        exp_q.push_back(b[6]);
        bus_write(DATA_A, d, 4'hF);
        bus_read(STAT_A);
        check("simul_status", mem_rdata, status(1, 1, 0, 4));
        repeat (5 * FRAME + 20) tick();
        check("drain_queue", exp_q.size(), 0);
        bus_read(STAT_A);
        check("drain_status", mem_rdata, 32'h0);
        rd_m = 32'h0;

        // Randomized register traffic with the UART idle
        for (int i = 0; i < 40; i++) begin
            a = $urandom; a[1:0] = 2'b0;
            a[22] = ($urandom_range(0, 3) != 0);
            ofs = $urandom_range(0, 3);
            a[3:2] = 2'(ofs);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; m = 4'($urandom_range(0, 15));
                if (ofs == 1) a[22] = 1'b0;
                bus_write(a, d, m);
                if (a[22] && ofs == 0 && m != 4'h0) led_m = d[5:0];
                check("rand_leds", {26'h0, LEDS}, {26'h0, led_m});
                check("rand_leds_al", {26'h0, leds_al}, {26'h0, ~led_m});
            end else begin
                bus_read(a);
                if (a[22]) rd_m = (ofs == 0) ? {26'h0, led_m} : 32'h0;
                check("rand_rdata", mem_rdata, rd_m);
                check("rand_io_sel", {31'h0, io_sel}, {31'h0, a[22]});
                check("rand_io_sel_al", {31'h0, io_sel_al}, {31'h0, a[22]});
            end
        end

        // Random bursts that never exceed capacity
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 5);
            a = $urandom; a[22] = 1'b0; a[3:2] = UART_DATA_OFS_TB();
            bus_write(a, $urandom, 4'hF);
            for (int j = 0; j < n; j++) begin
                byt = 8'($urandom);
                exp_q.push_back(byt);
                d = $urandom; d[7:0] = byt;
                bus_write(DATA_A, d, 4'($urandom_range(1, 15)));
            end
            repeat (n * FRAME + 20) tick();
            check("burst_drain", exp_q.size(), 0);
            bus_read(STAT_A);
            check("burst_status", mem_rdata, 32'h0);
            rd_m = 32'h0;
        end

        // Reset during data bit 3 aborts the frame and empties the FIFO
        mon_en = 1'b0;
        byt = 8'($urandom);
        bus_write(DATA_A, {24'h0, byt}, 4'hF);
        p0 = cyc + 1;
        bus_write(DATA_A, $urandom, 4'hF);
        bus_write(DATA_A, $urandom, 4'hF);
        while (cyc < p0 + 44) tick();
        check("pre_reset_bit3", {31'h0, TXD}, {31'h0, byt[3]});
        reset = 1'b0;
        tick();
        check("abort_txd", {31'h0, TXD}, 32'h1);
        tick();
        reset = 1'b1;
        led_m = 6'h0;
        check("abort_leds", {26'h0, LEDS}, 32'h0);
        bus_read(STAT_A);
        check("abort_status", mem_rdata, 32'h0);
        lows = 0;
        repeat (250) begin
            tick();
            if (TXD !== 1'b1) lows++;
        end
        check("no_frames", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic [1:0] UART_DATA_OFS_TB();
        return 2'd1;
    endfunction

endmodule

// File: doc/soc_io.md
Name: soc_io

Overview:
- Memory-mapped I/O subsystem sitting beside the RAM on the processor's memory bus.
- Replaces fixed LED wiring from x10 and the tied-off TXD with processor-writable registers.
- Contains a parametrised LED register, a buffered 8N1 UART transmitter and a status register.
- The SoC top routes any access with mem_addr[IO_SEL_BIT]=1 here; the SoC muxes read data by that same bit.

Parameters:
- LED_WIDTH, 6, width of the LED output register.
- LED_ACTIVE_LOW, 1, 1 = LEDS pins are the inverted register value (board); 0 = direct (bench).
- CLK_FREQ_HZ, 12000000, clk frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide, must be >= 2).
- TX_DEPTH, 16, UART TX FIFO entries; power of two, >= 2.
- IO_SEL_BIT, 22, address bit selecting the I/O page.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- mem_addr  in  32  byte address from processor.
- mem_wdata  in  32  write data.
- mem_wmask  in  4  byte write enables; any nonzero bit = write.
- mem_rstrb  in  1  read strobe.
- mem_rdata  out  32  registered read data.
- io_sel  out  1  combinational mem_addr[IO_SEL_BIT], used by SoC read mux.
- LEDS  out  LED_WIDTH  LED pins.
- TXD  out  1  UART serial out, idle high.

Behaviour:
- Register decode uses mem_addr[3:2] when io_sel=1; accesses with io_sel=0 are ignored.
- Offset 0x0 LED (RW): write with any wmask bit loads led_reg <= wdata[LED_WIDTH-1:0]; read returns led_reg zero-extended.
- Offset 0x4 UART_DATA (W): write pushes wdata[7:0] into the TX FIFO; reads return 0.
- Offset 0x8 UART_STATUS (R), bit fields:
  - bit0 fifo_full; bit1 tx_busy (FIFO non-empty or shifter not IDLE); bit2 overflow (sticky).
  - bits[15:8] fifo_count.
  - A read clears overflow on the following edge. An overflow set event in the same cycle wins over the clear.
- Offset 0xC: reads 0, writes ignored.
- Read latency is 1 cycle: on mem_rstrb&io_sel, mem_rdata is registered next edge and held until the next strobe.
- Reset (reset=0 at an edge) sets: led_reg=0, mem_rdata=0, FIFO empty, overflow=0, shifter IDLE, TXD=1, bit counter and divider=0.
  - LEDS during reset = all ones if LED_ACTIVE_LOW, else 0.
  - Reset mid-frame aborts the frame immediately; TXD=1 on the next cycle.
- FIFO: synchronous, count width clog2(TX_DEPTH)+1.
  - Push while full is dropped and sets overflow.
  - Simultaneous push and pop when full: both happen, no overflow.
  - Push into empty: data is not popped in the same cycle; earliest pop is the next cycle.
- UART state machine:
  - IDLE: TXD=1. If FIFO non-empty: pop, latch byte, go to START.
  - START: TXD=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: LSB first, 8 bits, CLKS_PER_BIT clocks each, then go to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT clocks, then go to IDLE. Back-to-back bytes start on the cycle after STOP ends.
- Frame length is exactly 10*CLKS_PER_BIT + 1 clocks from pop to the next START when the FIFO is pre-loaded (1 cycle in IDLE).
- TXD is registered, so there are no glitches.

Decomposition:
- Package soc_io_pkg holds:
  - register offsets (LED_OFS, UART_DATA_OFS, UART_STATUS_OFS);
  - status bit positions;
  - the UART state enum (IDLE, START, DATA, STOP).
- Sub-module sync_fifo (WIDTH=8, DEPTH=TX_DEPTH) provides push, pop, full, empty and count; it is reusable for a later RX path.
- The UART shifter and the register decode stay in soc_io.

Test Plan (CLK_FREQ_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10; TX_DEPTH=4; LED_ACTIVE_LOW=0):
- Reset values: hold reset=0 for 3 cycles, release, then read STATUS -> mem_rdata=0x00000000 one cycle after strobe; TXD=1; LEDS=0.
- LED: write 0x0000003F to 0x400000 with wmask=0xF -> LEDS=6'h3F next cycle; read back returns 0x3F. Rebuild with LED_ACTIVE_LOW=1 -> LEDS=6'h00.
- Single frame: write 0x55 to 0x400004 -> TXD low for 10 clocks, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then high for 10 clocks; tx_busy=1 during the frame and 0 after.
- Overflow: write 6 bytes back-to-back -> the first byte pops immediately, 4 are queued, the 6th is dropped. STATUS then reads full=1, overflow=1, count=4. A second STATUS read shows overflow=0.
- Simultaneous push/pop: push exactly as IDLE pops with the FIFO full -> count stays 4, overflow stays 0, and all bytes appear on TXD in order.
- Reset mid-frame: assert reset during DATA bit 3 -> TXD=1 next cycle, FIFO count=0, no further frames.
